// File: rtl/ram_loader.sv
// ram_loader: copies a stream of program bytes from a source into a small RAM.
// Each byte is written, then (when VERIFY=1) read back and compared before the
// next address is requested.
//
// Ports
//   clk        system clock, all state changes on the rising edge
//   clr        synchronous active-high reset
//   start      pulse that begins a load at address 0 (ignored while busy)
//   DataIn     program byte from the source
//   DataValid  source has a byte on DataIn
//   DataReady  loader accepts DataIn this cycle
//   Addrs      RAM address
//   BusOut     byte driven to the RAM data input, high-Z when not writing
//   BusIn      RAM read-back data
//   RAMIn      RAM write enable
//   RAMOut     RAM output enable
//   Busy       load in progress
//   Done       load completed without error
//   Error      verify mismatch occurred
//   ErrAddr    address of the first mismatch
module ram_loader #(
  parameter logic [3:0] LAST_ADDR = 4'hF,
  parameter bit         VERIFY    = 1'b1
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       start,
  input  logic [7:0] DataIn,
  input  logic       DataValid,
  output logic       DataReady,
  output logic [3:0] Addrs,
  output logic [7:0] BusOut,
  input  logic [7:0] BusIn,
  output logic       RAMIn,
  output logic       RAMOut,
  output logic       Busy,
  output logic       Done,
  output logic       Error,
  output logic [3:0] ErrAddr
);

  localparam int unsigned AW = 4;
  localparam int unsigned DW = 8;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_WRITE = 3'd2,
    S_READ  = 3'd3,
    S_CHECK = 3'd4,
    S_DONE  = 3'd5,
    S_ERR   = 3'd6
  } state_t;

  state_t        r_state;
  logic [AW-1:0] r_addr;
  logic [AW-1:0] r_err_addr;
  logic [DW-1:0] r_byte;

  logic w_last;
  logic w_match;

  assign w_last  = (r_addr == LAST_ADDR);
  assign w_match = (BusIn == r_byte);

  // State register plus the address, error-address and byte registers.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_err_addr <= '0;
      r_byte     <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            r_state    <= S_LOAD;
            r_addr     <= '0;
            r_err_addr <= '0;
          end
        end
        S_LOAD: begin
          if (DataValid) begin
            r_byte  <= DataIn;
            r_state <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (VERIFY) begin
            r_state <= S_READ;
          end else if (w_last) begin
            r_state <= S_DONE;
          end else begin
            r_addr  <= r_addr + AW'(1);
            r_state <= S_LOAD;
          end
        end
        // RAM registers its output on this edge; compare happens in CHECK.
        S_READ: r_state <= S_CHECK;
        S_CHECK: begin
          if (!w_match) begin
            r_err_addr <= r_addr;
            r_state    <= S_ERR;
          end else if (w_last) begin
            r_state <= S_DONE;
          end else begin
            r_addr  <= r_addr + AW'(1);
            r_state <= S_LOAD;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Outputs decoded straight from the state register.
  assign DataReady = (r_state == S_LOAD);
  assign RAMIn     = (r_state == S_WRITE);
  assign RAMOut    = (r_state == S_READ) || (r_state == S_CHECK);
  assign Busy      = (r_state == S_LOAD) || (r_state == S_WRITE) ||
                     (r_state == S_READ) || (r_state == S_CHECK);
  assign Done      = (r_state == S_DONE);
  assign Error     = (r_state == S_ERR);
  assign Addrs     = r_addr;
  assign ErrAddr   = r_err_addr;
  assign BusOut    = (r_state == S_WRITE) ? r_byte : {DW{1'bz}};

endmodule

// File: tb/tb_ram_loader.sv
// Bench for ram_loader: behavioural RAM, scoreboard of expected writes checked
// by a monitor, and directed load scenarios for both parameterisations.
module tb_ram_loader;

  logic       clk = 1'b0;
  logic       clr;
  logic       start;
  logic [7:0] DataIn;
  logic       DataValid;
  logic       DataReady;
  logic [3:0] Addrs;
  wire  [7:0] BusOut;
  logic [7:0] BusIn;
  logic       RAMIn, RAMOut, Busy, Done, Error;
  logic [3:0] ErrAddr;

  logic       start2;
  logic [7:0] DataIn2;
  logic       DataValid2;
  logic       DataReady2;
  logic [3:0] Addrs2;
  wire  [7:0] BusOut2;
  logic [7:0] BusIn2;
  logic       RAMIn2, RAMOut2, Busy2, Done2, Error2;
  logic [3:0] ErrAddr2;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  ram_loader u_dut (
    .clk(clk), .clr(clr), .start(start), .DataIn(DataIn), .DataValid(DataValid),
    .DataReady(DataReady), .Addrs(Addrs), .BusOut(BusOut), .BusIn(BusIn),
    .RAMIn(RAMIn), .RAMOut(RAMOut), .Busy(Busy), .Done(Done), .Error(Error),
    .ErrAddr(ErrAddr)
  );

  ram_loader #(.LAST_ADDR(4'h3), .VERIFY(1'b0)) u_dut2 (
    .clk(clk), .clr(clr), .start(start2), .DataIn(DataIn2), .DataValid(DataValid2),
    .DataReady(DataReady2), .Addrs(Addrs2), .BusOut(BusOut2), .BusIn(BusIn2),
    .RAMIn(RAMIn2), .RAMOut(RAMOut2), .Busy(Busy2), .Done(Done2), .Error(Error2),
    .ErrAddr(ErrAddr2)
  );

  // RAM models: write on RAMIn, register output on RAMOut.
  logic [7:0] mem  [16];
  logic [7:0] mem2 [16];
  logic [7:0] ram_q, ram_q2;
  logic       inj;

  always @(posedge clk) begin
    if (RAMIn)  mem[Addrs] <= BusOut;
    if (RAMOut) ram_q <= (inj && Addrs == 4'h6) ? 8'hFF : mem[Addrs];
  end
  always @(posedge clk) begin
    if (RAMIn2)  mem2[Addrs2] <= BusOut2;
    if (RAMOut2) ram_q2 <= mem2[Addrs2];
  end
  assign BusIn   = ram_q;
  assign BusIn2  = ram_q2;
  assign DataIn2 = 8'hA0 + {4'h0, Addrs2};

  logic ramout2_seen = 1'b0;
  always @(negedge clk) if (RAMOut2) ramout2_seen = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Scoreboard of expected RAM writes.
  typedef struct packed { logic [3:0] a; logic [7:0] d; } wr_t;
  wr_t q[$];

  always @(negedge clk) begin
    if (RAMIn || RAMOut) chk("we_oe_exclusive", 32'(RAMIn && RAMOut), 32'd0);
    if (RAMIn) begin
      if (q.size() == 0) begin
        chk("unexpected_write", 32'(Addrs), 32'hFFFF);
      end else begin
        wr_t e;
        e = q.pop_front();
        chk("write_addr", 32'(Addrs), 32'(e.a));
        chk("write_data", 32'(BusOut), 32'(e.d));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!DataReady && n < 20) begin tick(); n++; end
    if (!DataReady) chk("ready_timeout", 32'd0, 32'd1);
  endtask

  // Offer one byte; the handshake edge is consumed before returning.
  task automatic send(input logic [7:0] b, input logic [3:0] a);
    DataIn    = b;
    DataValid = 1'b1;
    wait_ready();
    q.push_back('{a: a, d: b});
    tick();
  endtask

  task automatic wait_flag(input bit which_err);
    int n = 0;
    while (!(which_err ? Error : Done) && n < 20) begin tick(); n++; end
    if (n >= 20) chk(which_err ? "error_timeout" : "done_timeout", 32'd0, 32'd1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  int t0;

  initial begin
    clr = 1'b1; start = 1'b0; DataIn = 8'h00; DataValid = 1'b0;
    start2 = 1'b0; DataValid2 = 1'b1; inj = 1'b0;
    tick(); tick();
    clr = 1'b0;

    // Reset state
    chk("rst_ready", 32'(DataReady), 0);
    chk("rst_busy",  32'(Busy), 0);
    chk("rst_done",  32'(Done), 0);
    chk("rst_error", 32'(Error), 0);
    chk("rst_addr",  32'(Addrs), 0);
    chk("rst_ramin", 32'(RAMIn), 0);
    chk("rst_ramout",32'(RAMOut), 0);

    // Full verified load with DataValid held high
    pulse_start();
    t0 = cyc;
    chk("start_ready", 32'(DataReady), 1);
    chk("start_addr",  32'(Addrs), 0);
    for (int i = 0; i < 16; i++) send(8'h10 + 8'(i), 4'(i));
    wait_flag(1'b0);
    chk("full_latency", 32'(cyc - t0), 32'd64);
    chk("full_error", 32'(Error), 0);
    chk("full_addr",  32'(Addrs), 32'hF);
    chk("full_busy",  32'(Busy), 0);
    for (int i = 0; i < 16; i++) chk("full_mem", 32'(mem[i]), 32'(8'h10 + 8'(i)));
    DataValid = 1'b0;

    // Source stall at address 3
    pulse_start();
    for (int i = 0; i < 16; i++) begin
      if (i == 3) begin
        wait_ready();
        DataValid = 1'b0;
        repeat (5) begin
          tick();
          chk("stall_ready", 32'(DataReady), 1);
          chk("stall_addr",  32'(Addrs), 3);
        end
      end
      send(8'h50 + 8'(i), 4'(i));
    end
    wait_flag(1'b0);
    chk("stall_done", 32'(Done), 1);
    chk("stall_mem3", 32'(mem[3]), 32'h53);
    chk("stall_mem15", 32'(mem[15]), 32'h5F);
    DataValid = 1'b0;

    // Verify failure at address 6, with start pulsed while busy
    inj = 1'b1;
    pulse_start();
    for (int i = 0; i < 7; i++) begin
      send(8'h36 + 8'(i), 4'(i));
      if (i == 2) begin
        pulse_start();
        chk("busy_start_addr", 32'(Addrs), 2);
        chk("busy_start_busy", 32'(Busy), 1);
      end
    end
    wait_flag(1'b1);
    chk("err_error",   32'(Error), 1);
    chk("err_erraddr", 32'(ErrAddr), 6);
    chk("err_done",    32'(Done), 0);
    chk("err_addr",    32'(Addrs), 6);
    chk("err_busy",    32'(Busy), 0);
    chk("err_mem6",    32'(mem[6]), 32'h3C);
    inj = 1'b0;
    DataValid = 1'b0;
    tick(); tick();
    chk("err_hold", 32'(Addrs), 6);

    // Restart from ERR, then clr during WRITE at address 9
    pulse_start();
    chk("restart_error",   32'(Error), 0);
    chk("restart_erraddr", 32'(ErrAddr), 0);
    chk("restart_addr",    32'(Addrs), 0);
    chk("restart_ready",   32'(DataReady), 1);
    for (int i = 0; i < 10; i++) send(8'hC0 + 8'(i), 4'(i));
    chk("pre_clr_ramin", 32'(RAMIn), 1);
    clr = 1'b1;
    DataValid = 1'b0;
    tick();
    clr = 1'b0;
    chk("clr_ready", 32'(DataReady), 0);
    chk("clr_ramin", 32'(RAMIn), 0);
    chk("clr_ramout",32'(RAMOut), 0);
    chk("clr_busy",  32'(Busy), 0);
    chk("clr_done",  32'(Done), 0);
    chk("clr_error", 32'(Error), 0);
    chk("clr_addr",  32'(Addrs), 0);
    chk("clr_erraddr", 32'(ErrAddr), 0);
    chk("clr_mem0",  32'(mem[0]), 32'hC0);
    chk("clr_mem9",  32'(mem[9]), 32'hC9);
    repeat (6) tick();
    chk("clr_idle_busy", 32'(Busy), 0);
    chk("sb_empty", 32'(q.size()), 0);

    // Write-only instance, LAST_ADDR=3
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    t0 = cyc;
    begin
      int n = 0;
      while (!Done2 && n < 20) begin tick(); n++; end
    end
    chk("wo_latency", 32'(cyc - t0), 32'd8);
    chk("wo_done",    32'(Done2), 1);
    chk("wo_addr",    32'(Addrs2), 3);
    chk("wo_ramout",  32'(ramout2_seen), 0);
    for (int i = 0; i < 4; i++) chk("wo_mem", 32'(mem2[i]), 32'(8'hA0 + 8'(i)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ram_loader.md
RAM_LOADER -- requirements
Module: ram_loader

Interface
- REQ-001 SHALL have parameter LAST_ADDR, default 4'hF, meaning the final RAM address written in one load (loads run from 0 to LAST_ADDR).
- REQ-002 SHALL have parameter VERIFY, default 1, meaning 1 = read back and compare every byte, 0 = write only.
- REQ-003 SHALL have port clk, input, 1, the single system clock; all state changes on its rising edge.
- REQ-004 SHALL have port clr, input, 1, reset; synchronous, active-high.
- REQ-005 SHALL have port start, input, 1, a pulse that begins a load at address 0.
- REQ-006 SHALL have port DataIn, input, 8, the program byte from the source.
- REQ-007 SHALL have port DataValid, input, 1, meaning the source has a byte on DataIn.
- REQ-008 SHALL have port DataReady, output, 1, meaning the loader accepts DataIn this cycle.
- REQ-009 SHALL have port Addrs, output, 4, the RAM address.
- REQ-010 SHALL have port BusOut, output, 8, the byte driven to the RAM BusIn; 8'bzzzz_zzzz when not writing.
- REQ-011 SHALL have port BusIn, input, 8, the RAM BusOut read-back data.
- REQ-012 SHALL have port RAMIn, output, 1, the RAM write enable.
- REQ-013 SHALL have port RAMOut, output, 1, the RAM output enable.
- REQ-014 SHALL have port Busy, output, 1, meaning a load is in progress.
- REQ-015 SHALL have port Done, output, 1, meaning the load completed without error.
- REQ-016 SHALL have port Error, output, 1, meaning a verify mismatch occurred.
- REQ-017 SHALL have port ErrAddr, output, 4, the address of the first mismatch.

Function
- REQ-018 SHALL implement the states IDLE, LOAD, WRITE, READ, CHECK, DONE and ERR as a registered FSM.
- REQ-019 IDLE/DONE/ERR: on start, SHALL go to LOAD with Addrs=0, and SHALL clear Done, Error and ErrAddr; start in any other state SHALL be ignored.
- REQ-020 LOAD: DataReady SHALL be 1; on DataValid=1 the loader SHALL latch DataIn into a byte register and go to WRITE; with DataValid=0 it SHALL wait indefinitely.
- REQ-021 DataReady SHALL be 1 only in LOAD, so exactly one byte is accepted per address.
- REQ-022 WRITE (1 cycle): RAMIn=1, RAMOut=0, BusOut=latched byte; next state SHALL be READ if VERIFY=1, else the advance step.
- REQ-023 READ (1 cycle): RAMIn=0, RAMOut=1, BusOut=Z; the RAM latches its output on this edge; next state SHALL be CHECK.
- REQ-024 CHECK (1 cycle): RAMOut=1; if BusIn equals the latched byte, the loader SHALL take the advance step; otherwise it SHALL set ErrAddr=Addrs and go to ERR.
- REQ-025 Advance step: if Addrs==LAST_ADDR go to DONE; otherwise Addrs<=Addrs+1 (4-bit, no wrap beyond LAST_ADDR) and go to LOAD.
- REQ-026 Throughput SHALL be 4 cycles per byte from handshake to the next DataReady with VERIFY=1, and 2 cycles with VERIFY=0.
- REQ-027 Busy SHALL be 1 in LOAD, WRITE, READ and CHECK, and 0 otherwise.
- REQ-028 Done SHALL be 1 only in DONE; Error SHALL be 1 only in ERR; both SHALL hold until start or clr.
- REQ-029 RAMIn and RAMOut SHALL never both be 1; both SHALL be 0 in IDLE, LOAD, DONE and ERR.
- REQ-030 Addrs SHALL hold its last value in DONE and ERR.
- REQ-031 All outputs SHALL be glitch-free, driven from registers or directly decoded from the state.

Reset
- REQ-032 When clr=1 at a clock edge, the block SHALL enter IDLE with Addrs=0, ErrAddr=0, the byte register at 0, DataReady=RAMIn=RAMOut=Busy=Done=Error=0, and BusOut=Z.
- REQ-033 clr mid-load SHALL abandon the load immediately; bytes already written stay in RAM; no further RAMIn pulse SHALL occur.
- REQ-034 clr SHALL take priority over start and DataValid in the same cycle.

Verification
- REQ-035 Full load, VERIFY=1: start, then 16 bytes 8'h10..8'h1F with DataValid held high -> RAM[i]=8'h10+i, Done=1 after 64 cycles, Error=0, Addrs=4'hF.
- REQ-036 Source stall: deassert DataValid for 5 cycles at address 3 -> DataReady stays 1, no RAMIn pulse, load resumes correctly.
- REQ-037 Verify fail: force BusIn to 8'hFF when the byte at address 6 is 8'h3C -> Error=1, ErrAddr=4'h6, Done=0, Addrs remains 6.
- REQ-038 VERIFY=0, LAST_ADDR=4'h3: load 4 bytes -> RAMOut never 1, Done=1 after 8 cycles.
- REQ-039 clr asserted during WRITE at address 9 -> next cycle IDLE, all outputs at reset values, BusOut=Z, RAM[0..9] written.
- REQ-040 start pulsed while Busy -> ignored; start pulsed in ERR -> Error clears, Addrs=0, DataReady=1.
